// File: rtl/dncctp_sched_pkg.sv
// Shared definitions for the DNCCTP slot scheduler.
//   state_t / St*  : scheduler FSM state encoding
//   MaxCh          : widest request vector the round-robin search handles
//   rr_pick()      : round-robin winner search, first set bit strictly after ptr
package dncctp_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StGrant = 2'd1;
  localparam state_t StGuard = 2'd2;

  localparam int unsigned MaxCh = 32;

  // Returns the index of the first set bit of req strictly after ptr, wrapping
  // modulo nch. Returns 0 when req is empty; callers test |req separately.
  function automatic int unsigned rr_pick(input logic [MaxCh-1:0] req,
                                          input int unsigned      ptr,
                                          input int unsigned      nch);
    int unsigned win;
    int unsigned c;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxCh; i++) begin
      c = (ptr + i) % nch;
      if (!found && (i <= nch) && req[c]) begin
        win   = c;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/slot_scheduler_if.sv
// Requester-side bus of the slot scheduler.
//   master : requesters / tick source (drive tick_en, req, abort)
//   slave  : the scheduler (drives grant, cur_ch, slot_start, slot_last, busy)
interface slot_scheduler_if #(
  parameter int unsigned NCH = 4
) ();

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           tick_en;
  logic [NCH-1:0] req;
  logic           abort;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] cur_ch;
  logic           slot_start;
  logic           slot_last;
  logic           busy;

  modport master (
    output tick_en, req, abort,
    input  grant, cur_ch, slot_start, slot_last, busy
  );

  modport slave (
    input  tick_en, req, abort,
    output grant, cur_ch, slot_start, slot_last, busy
  );

endinterface

// File: rtl/slot_timer.sv
// Modulo-LEN slot counter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance by one (wraps LEN-1 -> 0)
//   clr        : synchronous clear, wins over en
//   cnt        : current count
//   term       : combinational, cnt == LEN-1
module slot_timer #(
  parameter  int unsigned LEN = 64,
  localparam int unsigned W   = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;

  assign term = (cnt_q == W'(LEN - 1));
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      // Explicit wrap so non-power-of-two lengths behave.
      cnt_q <= term ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/slot_scheduler.sv
// Time-division scheduler sharing one tick-gated datapath among NCH requesters.
// Grants one channel for SLOT_LEN enabled ticks, waits GUARD_LEN dead cycles,
// then re-arbitrates round-robin. slot_last stands in for the counter carry-out.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.tick_en    : global tick enable, slot counter advances only when high
//   bus.req        : per-channel request levels
//   bus.abort      : end the current slot early (GRANT only)
//   bus.grant      : registered one-hot grant
//   bus.cur_ch     : index of granted channel (holds when grant is 0)
//   bus.slot_start : pulse on the first grant cycle of each slot
//   bus.slot_last  : combinational, final tick of a slot
//   bus.busy       : state != IDLE
module slot_scheduler
  import dncctp_sched_pkg::*;
#(
  parameter int unsigned NCH       = 4,  // 2..MaxCh
  parameter int unsigned SLOT_LEN  = 64,
  parameter int unsigned GUARD_LEN = 2
) (
  input logic               clk,
  input logic               rst_n,
  slot_scheduler_if.slave   bus
);

  localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW        = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned GW        = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  localparam int unsigned GuardLast = (GUARD_LEN > 0) ? GUARD_LEN - 1 : 0;

  state_t         state_q, state_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [CHW-1:0] cur_ch_q, cur_ch_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic           slot_start_q, slot_start_d;
  logic [GW-1:0]  guard_cnt_q, guard_cnt_d;

  logic           in_grant;
  logic           slot_last;
  logic           end_slot;
  logic           timer_clr;
  logic           timer_term;
  logic [SW-1:0]  slot_cnt;

  logic [MaxCh-1:0] req_ext;
  logic [CHW-1:0]   arb_ptr;
  logic [CHW-1:0]   arb_win;
  logic             req_any;
  logic             launch;

  assign in_grant  = (state_q == StGrant);
  // Gated by rst_n so a reset cycle never emits a carry-out.
  assign slot_last = rst_n & in_grant & bus.tick_en & timer_term;
  assign end_slot  = in_grant & (slot_last | bus.abort);

  slot_timer #(
    .LEN (SLOT_LEN)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_grant & bus.tick_en),
    .clr   (timer_clr),
    .cnt   (slot_cnt),
    .term  (timer_term)
  );

  // With GUARD_LEN == 0 the re-arbitration happens in the closing GRANT cycle,
  // before rr_q has been updated, so the pointer is taken from cur_ch_q there.
  assign arb_ptr = in_grant ? cur_ch_q : rr_q;
  assign req_ext = MaxCh'(bus.req);
  assign req_any = |bus.req;
  assign arb_win = CHW'(rr_pick(req_ext, 32'(arb_ptr), NCH));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cur_ch_d     = cur_ch_q;
    rr_d         = rr_q;
    slot_start_d = 1'b0;
    guard_cnt_d  = guard_cnt_q;
    timer_clr    = 1'b0;
    launch       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_any) begin
          launch = 1'b1;
        end
      end

      StGrant: begin
        if (end_slot) begin
          grant_d   = '0;
          rr_d      = cur_ch_q;
          timer_clr = 1'b1;
          if (GUARD_LEN > 0) begin
            state_d     = StGuard;
            guard_cnt_d = '0;
          end else if (req_any) begin
            launch = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StGuard: begin
        if (guard_cnt_q == GW'(GuardLast)) begin
          guard_cnt_d = '0;
          if (req_any) begin
            launch = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    if (launch) begin
      state_d      = StGrant;
      grant_d      = {{(NCH-1){1'b0}}, 1'b1} << arb_win;
      cur_ch_d     = arb_win;
      slot_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      cur_ch_q     <= '0;
      rr_q         <= CHW'(NCH - 1);  // ch0 wins first
      slot_start_q <= 1'b0;
      guard_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cur_ch_q     <= cur_ch_d;
      rr_q         <= rr_d;
      slot_start_q <= slot_start_d;
      guard_cnt_q  <= guard_cnt_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.slot_start = slot_start_q;
  assign bus.slot_last  = slot_last;
  assign bus.busy       = (state_q != StIdle);

`ifndef SYNTHESIS
  // Enabled ticks seen in the current slot, restarted whenever a slot ends.
  int unsigned ticks_q;
  always_ff @(posedge clk) begin
    if (!rst_n || !in_grant || end_slot) begin
      ticks_q <= 0;
    end else if (bus.tick_en) begin
      ticks_q <= ticks_q + 1;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  a_start_has_grant : assert property (@(posedge clk) disable iff (!rst_n)
    slot_start_q |-> (grant_q != '0));
  a_no_grant_in_guard : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StGuard) |-> (grant_q == '0));
  a_last_after_len : assert property (@(posedge clk) disable iff (!rst_n)
    slot_last |-> (ticks_q == SLOT_LEN - 1));
  a_len_gives_last : assert property (@(posedge clk) disable iff (!rst_n)
    (in_grant && bus.tick_en && ticks_q == SLOT_LEN - 1) |-> slot_last);
  a_cnt_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !in_grant |-> (slot_cnt == '0));
`endif

endmodule

// File: tb/tb_slot_scheduler.sv
// Bench for slot_scheduler: two instances (GUARD_LEN=2 and GUARD_LEN=0) share
// one stimulus stream; a slot-level model is compared every cycle and directed
// literal checks pin the expected timelines.
module tb_slot_scheduler;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SLOT = 4;

  logic           clk;
  logic           rst_n;
  logic           tick_en;
  logic           abort;
  logic [NCH-1:0] req;

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;
  int cyc      = 0;

  slot_scheduler_if #(.NCH(NCH)) if_a ();
  slot_scheduler_if #(.NCH(NCH)) if_b ();

  assign if_a.tick_en = tick_en;
  assign if_a.req     = req;
  assign if_a.abort   = abort;
  assign if_b.tick_en = tick_en;
  assign if_b.req     = req;
  assign if_b.abort   = abort;

  slot_scheduler #(.NCH(NCH), .SLOT_LEN(SLOT), .GUARD_LEN(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  slot_scheduler #(.NCH(NCH), .SLOT_LEN(SLOT), .GUARD_LEN(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slot-level model: who owns the datapath, how many ticks it has used,
  // how many dead cycles remain, and whose turn was last.
  int m_owner[2];
  int m_ticks[2];
  int m_guard_left[2];
  int m_ptr[2];
  int m_cur[2];
  bit m_fresh[2];

  function automatic int guard_of(input int m);
    return (m == 0) ? 2 : 0;
  endfunction

  task automatic try_grant(input int m, input logic [NCH-1:0] r);
    bit found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int c = (m_ptr[m] + k) % NCH;
      if (!found && r[c]) begin
        found        = 1'b1;
        m_owner[m]   = c;
        m_cur[m]     = c;
        m_fresh[m]   = 1'b1;
        m_ticks[m]   = 0;
      end
    end
  endtask

  task automatic model_step(input int m, input logic rst, input logic [NCH-1:0] r,
                            input logic tk, input logic ab);
    bit last;
    if (rst !== 1'b1) begin
      m_owner[m] = -1; m_ticks[m] = 0; m_guard_left[m] = 0;
      m_ptr[m] = NCH - 1; m_cur[m] = 0; m_fresh[m] = 1'b0;
    end else begin
      last = (m_owner[m] >= 0) && (tk == 1'b1) && (m_ticks[m] == SLOT - 1);
      m_fresh[m] = 1'b0;
      if (m_owner[m] >= 0) begin
        if (last || ab == 1'b1) begin
          m_ptr[m]   = m_owner[m];
          m_owner[m] = -1;
          m_ticks[m] = 0;
          if (guard_of(m) > 0) m_guard_left[m] = guard_of(m);
          else try_grant(m, r);
        end else if (tk == 1'b1) begin
          m_ticks[m]++;
        end
      end else if (m_guard_left[m] > 0) begin
        m_guard_left[m]--;
        if (m_guard_left[m] == 0) try_grant(m, r);
      end else begin
        try_grant(m, r);
      end
    end
  endtask

  // Single compare process: outputs vs model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] eg, ec, es, el, eb;
    logic [31:0] ag, ac, as_, al, ab_;
    for (int m = 0; m < 2; m++) begin
      eg  = (m_owner[m] >= 0) ? (32'd1 << m_owner[m]) : 32'd0;
      ec  = 32'(m_cur[m]);
      es  = {31'd0, m_fresh[m]};
      eb  = {31'd0, (m_owner[m] >= 0) || (m_guard_left[m] > 0)};
      el  = {31'd0, (rst_n === 1'b1) && (m_owner[m] >= 0) && (tick_en === 1'b1)
                    && (m_ticks[m] == SLOT - 1)};
      ag  = (m == 0) ? 32'(if_a.grant)      : 32'(if_b.grant);
      ac  = (m == 0) ? 32'(if_a.cur_ch)     : 32'(if_b.cur_ch);
      as_ = (m == 0) ? 32'(if_a.slot_start) : 32'(if_b.slot_start);
      al  = (m == 0) ? 32'(if_a.slot_last)  : 32'(if_b.slot_last);
      ab_ = (m == 0) ? 32'(if_a.busy)       : 32'(if_b.busy);
      if (check_en) begin
        check($sformatf("model dut%0d t=%0t grant", m, $time), ag, eg);
        check($sformatf("model dut%0d t=%0t cur_ch", m, $time), ac, ec);
        check($sformatf("model dut%0d t=%0t slot_start", m, $time), as_, es);
        check($sformatf("model dut%0d t=%0t slot_last", m, $time), al, el);
        check($sformatf("model dut%0d t=%0t busy", m, $time), ab_, eb);
      end
      model_step(m, rst_n, req, tick_en, abort);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) next_cycle();
  endtask

  // Leaves the bench at cycle 0: DUTs idle, inputs may be set for that cycle.
  task automatic do_reset();
    rst_n = 1'b0; req = '0; abort = 1'b0; tick_en = 1'b1;
    next_cycle();
    next_cycle();
    rst_n    = 1'b1;
    check_en = 1'b1;
    cyc      = 0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; abort = 1'b0; tick_en = 1'b1;

    // 1: single requester ch2, guard 2
    do_reset();
    req = 4'b0100; #1;
    check("t1 c0 grant", 32'(if_a.grant), 32'h0);
    check("t1 c0 busy", 32'(if_a.busy), 32'h0);
    goto(1); #1;
    check("t1 c1 grant", 32'(if_a.grant), 32'h4);
    check("t1 c1 slot_start", 32'(if_a.slot_start), 32'h1);
    check("t1 c1 cur_ch", 32'(if_a.cur_ch), 32'h2);
    goto(2); #1;
    check("t1 c2 slot_start", 32'(if_a.slot_start), 32'h0);
    goto(4); #1;
    check("t1 c4 slot_last", 32'(if_a.slot_last), 32'h1);
    goto(5); #1;
    check("t1 c5 grant", 32'(if_a.grant), 32'h0);
    check("t1 c5 busy", 32'(if_a.busy), 32'h1);
    goto(6); #1;
    check("t1 c6 grant", 32'(if_a.grant), 32'h0);
    goto(7); #1;
    check("t1 c7 grant", 32'(if_a.grant), 32'h4);
    check("t1 c7 slot_start", 32'(if_a.slot_start), 32'h1);

    // 2: all requesting, rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      goto(1 + 6 * k); #1;
      check($sformatf("t2 slot%0d grant", k), 32'(if_a.grant), 32'd1 << (k % 4));
      check($sformatf("t2 slot%0d cur_ch", k), 32'(if_a.cur_ch), 32'(k % 4));
      check($sformatf("t2 slot%0d start", k), 32'(if_a.slot_start), 32'h1);
      if (k < 4) begin
        goto(5 + 6 * k); #1;
        check($sformatf("t2 guard%0d grant", k), 32'(if_a.grant), 32'h0);
      end
    end

    // 3: alternating tick_en stretches the slot to 7 cycles
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      goto(c);
      tick_en = (c % 2 == 1) || (c == 8);
      #1;
      if (c == 5) check("t3 c5 slot_last", 32'(if_a.slot_last), 32'h0);
      if (c == 6) check("t3 c6 frozen slot_last", 32'(if_a.slot_last), 32'h0);
      if (c == 7) begin
        check("t3 c7 slot_last", 32'(if_a.slot_last), 32'h1);
        check("t3 c7 grant", 32'(if_a.grant), 32'h1);
      end
      if (c == 8) check("t3 c8 grant", 32'(if_a.grant), 32'h0);
    end
    tick_en = 1'b1;

    // 4: abort mid-slot, then abort coinciding with slot_last
    do_reset();
    req = 4'b0011;
    goto(2); abort = 1'b1; #1;
    check("t4 c2 slot_last", 32'(if_a.slot_last), 32'h0);
    goto(3); abort = 1'b0; #1;
    check("t4 c3 grant", 32'(if_a.grant), 32'h0);
    check("t4 c3 busy", 32'(if_a.busy), 32'h1);
    check("t4 c3 b grant", 32'(if_b.grant), 32'h2);
    check("t4 c3 b start", 32'(if_b.slot_start), 32'h1);
    goto(4); #1;
    check("t4 c4 grant", 32'(if_a.grant), 32'h0);
    goto(5); #1;
    check("t4 c5 grant", 32'(if_a.grant), 32'h2);
    check("t4 c5 cur_ch", 32'(if_a.cur_ch), 32'h1);
    goto(8); abort = 1'b1; #1;
    check("t4 c8 slot_last with abort", 32'(if_a.slot_last), 32'h1);
    goto(9); abort = 1'b0; #1;
    check("t4 c9 grant", 32'(if_a.grant), 32'h0);

    // 5: reset while ch2 holds the slot at cnt=2
    do_reset();
    req = 4'b0100;
    goto(3); #1;
    check("t5 c3 grant", 32'(if_a.grant), 32'h4);
    rst_n = 1'b0; req = 4'b1111;
    goto(4); #1;
    check("t5 c4 grant", 32'(if_a.grant), 32'h0);
    check("t5 c4 busy", 32'(if_a.busy), 32'h0);
    check("t5 c4 cur_ch", 32'(if_a.cur_ch), 32'h0);
    rst_n = 1'b1;
    goto(5); #1;
    check("t5 c5 grant", 32'(if_a.grant), 32'h1);
    check("t5 c5 cur_ch", 32'(if_a.cur_ch), 32'h0);

    // 6: GUARD_LEN=0 back-to-back slots
    do_reset();
    req = 4'b0011;
    goto(4); #1;
    check("t6 c4 b slot_last", 32'(if_b.slot_last), 32'h1);
    goto(5); #1;
    check("t6 c5 b grant", 32'(if_b.grant), 32'h2);
    check("t6 c5 b start", 32'(if_b.slot_start), 32'h1);
    check("t6 c5 b busy", 32'(if_b.busy), 32'h1);
    goto(8); #1;
    check("t6 c8 b slot_last", 32'(if_b.slot_last), 32'h1);
    goto(9); #1;
    check("t6 c9 b grant", 32'(if_b.grant), 32'h1);
    check("t6 c9 b start", 32'(if_b.slot_start), 32'h1);

    req = '0;
    goto(30);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/slot_scheduler.md
Name: slot_scheduler

Overview:
- Time-division scheduler that shares one tick-gated datapath among NCH requesters.
- Grants one requester at a time for a slot of exactly SLOT_LEN enabled ticks, inserts GUARD_LEN dead cycles, then re-arbitrates round-robin.
- Sits between requesting channels and the shared modulo counter/datapath in the DNCCTP subsystem; its slot_last pulse plays the role of the counter carry-out.

Parameters:
- NCH, 4, number of requesters (>=2).
- SLOT_LEN, 64, enabled ticks per slot (>=2).
- GUARD_LEN, 2, dead clk cycles between slots (0 = back-to-back).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- tick_en  in  1  global tick enable; slot counter advances only when high.
- req  in  NCH  per-channel request level.
- abort  in  1  terminate current slot early.
- grant  out  NCH  one-hot grant, registered.
- cur_ch  out  max(1,$clog2(NCH))  index of the granted channel.
- slot_start  out  1  one-cycle pulse on the first grant cycle of each slot.
- slot_last  out  1  combinational; high on the final tick of a slot.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, grant 0, cur_ch 0, slot_start 0, busy 0, slot counter 0, guard counter 0, rr pointer NCH-1, so ch0 has first priority. slot_last is 0 because it is gated by GRANT.
- Reset mid-operation: every register returns to its reset value at the next edge with rst_n low. No slot_last is produced.
- FSM states: IDLE, GRANT, GUARD.
- Arbitration is round-robin. The winner is the first set req bit strictly after the rr pointer, wrapping. Arbitration is not gated by tick_en.
- IDLE:
  - any req set → next edge: GRANT, grant one-hot set, cur_ch = winner, slot counter 0, slot_start = 1 for that cycle.
  - Latency from req sampled to grant visible is 1 cycle.
- GRANT:
  - Slot counter (width $clog2(SLOT_LEN)) increments on cycles with tick_en=1 and freezes when tick_en=0.
  - slot_last = (state==GRANT) & tick_en & (cnt==SLOT_LEN-1).
  - On the edge closing a slot_last cycle: grant→0, rr pointer←cur_ch, counter←0.
  - Then: GUARD if GUARD_LEN>0. If GUARD_LEN==0, arbitrate in the same cycle: any req → new GRANT with slot_start, else IDLE.
  - Dropping req during a slot does not shorten the slot.
- abort:
  - In GRANT, ends the slot at the next edge exactly as above, but slot_last is not asserted (unless it coincides with the natural last tick).
  - abort together with slot_last is a normal end, and slot_last stays high.
  - abort is ignored in IDLE and GUARD.
- GUARD:
  - grant 0 for exactly GUARD_LEN clk cycles. The guard counter is not tick-gated.
  - On the last guard cycle, arbitrate with req sampled that cycle: any req → GRANT with slot_start next edge, else IDLE.
- cur_ch holds its last value when grant is 0. It is meaningful only while grant != 0.
- Concurrent assertions (module-local):
  - grant is onehot0.
  - slot_start implies grant != 0.
  - Between slot_start and slot_last exactly SLOT_LEN tick_en cycles occur, absent abort.
  - No grant during GUARD.

Decomposition:
- Package dncctp_sched_pkg: state enum typedef (IDLE/GRANT/GUARD) and a function for the round-robin next-winner search.
- One sub-module, slot_timer: a modulo-SLOT_LEN counter with en, clr and combinational terminal flag. The scheduler FSM drives its en (tick_en & GRANT) and clr.

Test Plan:
1. NCH=4, SLOT_LEN=4, GUARD_LEN=2, tick_en=1; req=0100 from cycle 0 and held → grant=0100 cycles 1-4, slot_start cycle 1, slot_last cycle 4, grant=0 cycles 5-6, grant=0100 again cycle 7 with slot_start.
2. req=1111 held, same config → grant sequence ch0,ch1,ch2,ch3,ch0; each slot 4 cycles separated by 2 guard cycles; cur_ch tracks 0,1,2,3,0.
3. req=0001, tick_en alternating 1/0 starting high on grant cycle → slot spans 7 clk cycles, slot_last on the 4th high tick, counter frozen on low cycles.
4. req=0011, abort pulsed on the 2nd tick of the ch0 slot → grant drops next edge, no slot_last, 2 guard cycles, then grant=0010.
5. rst_n low for 1 cycle while ch2 granted at cnt=2 → next cycle grant=0, busy=0, cur_ch=0; with req=1111 after release, first grant is ch0.
6. GUARD_LEN=0, req=0011 held → ch0 slot then ch1 grant on the cycle right after ch0's slot_last, slot_start pulses on each, no idle gap.
